// File: rtl/divider_burst_controller_if.sv
// Host-side handshake bundle for the divider burst controller: configuration
// offer/accept, start/abort control and the status flags returned to the host.
interface divider_burst_controller_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] cfg_target;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             cfg_error;

  // Host side: offers configuration and control, observes status.
  modport master (
    output cfg_target, cfg_count, cfg_valid, start, abort,
    input  cfg_ready, busy, done, cfg_error
  );

  // Controller side: consumes configuration and control, drives status.
  modport slave (
    input  cfg_target, cfg_count, cfg_valid, start, abort,
    output cfg_ready, busy, done, cfg_error
  );
endinterface

// File: rtl/divider_burst_controller.sv
// Sequencing controller for the pulse-clock divider: takes a validated divide
// configuration, drives the counter's enable/reset/target and produces the
// divided output as a burst of N edges or continuously, with start/abort
// control and done/busy status. Every output is a register.
module divider_burst_controller #(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = 16,
  parameter int MIN_TARGET = 2,
  parameter int PIPE_COMP  = 1
) (
  input  logic                       pulse_clock,
  input  logic                       external_reset_n,
  divider_burst_controller_if.slave  host,
  input  logic                       div_toggle,
  output logic                       div_enable,
  output logic                       div_reset,
  output logic [WIDTH-1:0]           div_target,
  output logic                       divided_clock
);

  localparam logic [WIDTH-1:0] MIN_T  = WIDTH'(MIN_TARGET);
  localparam logic [WIDTH-1:0] PIPE_W = WIDTH'(PIPE_COMP);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_PRIME, S_RUN, S_HOLDOFF, S_FINISH
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] target_reg_q;
  logic [CNT_W-1:0] count_reg_q;
  logic [CNT_W-1:0] edges_left_q;
  logic [WIDTH-1:0] div_target_q;
  logic             div_enable_q;
  logic             div_reset_q;
  logic             divided_clock_q;
  logic             busy_q;
  logic             done_q;
  logic             cfg_ready_q;
  logic             cfg_error_q;
  logic             in_burst;

  // Abort is only honoured while a burst is actually in progress.
  assign in_burst = (state_q == S_PRIME) || (state_q == S_RUN) ||
                    (state_q == S_HOLDOFF);

  // Controller FSM; each transition also loads the outputs of the state it enters.
  // NOTE: every register here uses non-blocking assignment so all state and
  // outputs update together from the same pre-edge values.
  always_ff @(posedge pulse_clock or negedge external_reset_n) begin
    if (!external_reset_n) begin
      state_q         <= S_IDLE;
      target_reg_q    <= '0;
      count_reg_q     <= '0;
      edges_left_q    <= '0;
      div_target_q    <= '0;
      div_enable_q    <= 1'b0;
      div_reset_q     <= 1'b1;
      divided_clock_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cfg_ready_q     <= 1'b0;
      cfg_error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (host.abort && in_burst) begin
        // Abort wins over a coincident div_toggle: no toggle, no decrement.
        state_q         <= S_ARMED;
        divided_clock_q <= 1'b0;
        div_enable_q    <= 1'b0;
        div_reset_q     <= 1'b1;
        busy_q          <= 1'b0;
        cfg_ready_q     <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE, S_ARMED: begin
            cfg_ready_q <= 1'b1;
            if (host.cfg_valid && cfg_ready_q) begin
              // A configuration handshake takes priority over start.
              if (host.cfg_target < MIN_T) begin
                cfg_error_q <= 1'b1;
              end else begin
                target_reg_q <= host.cfg_target;
                count_reg_q  <= host.cfg_count;
                div_target_q <= host.cfg_target - PIPE_W;
                cfg_error_q  <= 1'b0;
                state_q      <= S_ARMED;
              end
            end else if (host.start && (state_q == S_ARMED)) begin
              state_q      <= S_PRIME;
              edges_left_q <= count_reg_q;
              div_target_q <= target_reg_q - PIPE_W;
              cfg_ready_q  <= 1'b0;
              busy_q       <= 1'b1;
            end
          end
          S_PRIME: begin
            state_q      <= S_RUN;
            div_reset_q  <= 1'b0;
            div_enable_q <= 1'b1;
          end
          S_RUN: begin
            if (div_toggle) begin
              divided_clock_q <= ~divided_clock_q;
              if ((count_reg_q != '0) && (edges_left_q != '0)) begin
                edges_left_q <= edges_left_q - CNT_W'(1);
              end
              state_q     <= S_HOLDOFF;
              div_reset_q <= 1'b1;
            end
          end
          S_HOLDOFF: begin
            if ((count_reg_q != '0) && (edges_left_q == '0)) begin
              state_q         <= S_FINISH;
              div_enable_q    <= 1'b0;
              divided_clock_q <= 1'b0;
              done_q          <= 1'b1;
              busy_q          <= 1'b0;
            end else begin
              state_q     <= S_RUN;
              div_reset_q <= 1'b0;
            end
          end
          S_FINISH: begin
            // Configuration is retained so a restart needs only start.
            state_q     <= S_ARMED;
            cfg_ready_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign host.cfg_ready = cfg_ready_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.cfg_error = cfg_error_q;
  assign div_enable     = div_enable_q;
  assign div_reset      = div_reset_q;
  assign div_target     = div_target_q;
  assign divided_clock  = divided_clock_q;

endmodule

// File: tb/tb_divider_burst_controller.sv
// Bench for divider_burst_controller: a behavioural counter drives div_toggle,
// stimulus pushes the expected divided_clock edges and done pulses (with the
// cycle they must appear on) into a scoreboard, and a monitor pops/compares.
module tb_divider_burst_controller;

  logic        pulse_clock = 1'b0;
  logic        external_reset_n = 1'b1;
  logic        div_toggle;
  logic        div_enable;
  logic        div_reset;
  logic [31:0] div_target;
  logic        divided_clock;

  divider_burst_controller_if #(.WIDTH(32), .CNT_W(16)) host_if ();

  divider_burst_controller #(
    .WIDTH(32), .CNT_W(16), .MIN_TARGET(2), .PIPE_COMP(1)
  ) dut (
    .pulse_clock      (pulse_clock),
    .external_reset_n (external_reset_n),
    .host             (host_if),
    .div_toggle       (div_toggle),
    .div_enable       (div_enable),
    .div_reset        (div_reset),
    .div_target       (div_target),
    .divided_clock    (divided_clock)
  );

  initial forever #5 pulse_clock = ~pulse_clock;

  // Cycle index: at the negedge after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge pulse_clock) cyc <= cyc + 1;

  // Counter model: counts enabled pulses since the last reset and flags the
  // div_target-th one.
  logic [31:0] cnt_q;
  always @(posedge pulse_clock or negedge external_reset_n) begin
    if (!external_reset_n)  cnt_q <= 32'd0;
    else if (div_reset)     cnt_q <= 32'd0;
    else if (div_enable)    cnt_q <= cnt_q + 32'd1;
  end
  assign div_toggle = div_enable && !div_reset && ((cnt_q + 32'd1) == div_target);

  typedef struct packed {
    logic [31:0] cyc;
    logic        is_done;
    logic        val;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  logic prev_dc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic handle_event(input ev_t got);
    ev_t want;
    check("event_expected", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      want = sb.pop_front();
      check(got.is_done ? "done_event" : "edge_event", 64'(got), 64'(want));
    end
  endtask

  // Monitor: every divided_clock change and every done cycle is an event.
  always @(negedge pulse_clock) begin
    if (!external_reset_n) begin
      prev_dc = 1'b0;
    end else begin
      if (divided_clock !== prev_dc) handle_event({32'(cyc), 1'b0, divided_clock});
      if (host_if.done === 1'b1)     handle_event({32'(cyc), 1'b1, 1'b1});
      prev_dc = divided_clock;
    end
  end

  // Expected burst: edges every T cycles after the start edge k, then FINISH
  // one cycle after the last edge (forced low + done).
  task automatic push_burst(input int t, input int c, input int k);
    for (int i = 1; i <= c; i++) sb.push_back({32'(k + t * i), 1'b0, 1'(i % 2)});
    if ((c % 2) == 1) sb.push_back({32'(k + t * c + 1), 1'b0, 1'b0});
    sb.push_back({32'(k + t * c + 1), 1'b1, 1'b1});
  endtask

  task automatic push_cont(input int t, input int n, input int k);
    for (int i = 1; i <= n; i++) sb.push_back({32'(k + t * i), 1'b0, 1'(i % 2)});
  endtask

  task automatic cfg_apply(input int t, input int c);
    @(negedge pulse_clock);
    host_if.cfg_valid  = 1'b1;
    host_if.cfg_target = 32'(t);
    host_if.cfg_count  = 16'(c);
    @(posedge pulse_clock);
    @(negedge pulse_clock);
    host_if.cfg_valid  = 1'b0;
  endtask

  task automatic pulse_start(output int k);
    @(negedge pulse_clock);
    host_if.start = 1'b1;
    @(posedge pulse_clock);
    #1 k = cyc;
  endtask

  task automatic release_start;
    @(negedge pulse_clock);
    host_if.start = 1'b0;
  endtask

  task automatic wait_armed(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge pulse_clock);
      if (!host_if.busy && host_if.cfg_ready) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic run_burst(input int t, input int c);
    int k;
    pulse_start(k);
    push_burst(t, c, k);
    release_start();
    wait_armed("burst_returns_armed", t * c + 10);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int k;
    int t;
    int c;
    int n;
    host_if.cfg_valid  = 1'b0;
    host_if.cfg_target = '0;
    host_if.cfg_count  = '0;
    host_if.start      = 1'b0;
    host_if.abort      = 1'b0;

    // Reset values.
    #3 external_reset_n = 1'b0;
    #1;
    check("rst_div_reset", 64'(div_reset), 64'd1);
    check("rst_outputs", 64'({div_enable, divided_clock, host_if.busy, host_if.done,
                              host_if.cfg_ready, host_if.cfg_error}), 64'd0);
    check("rst_div_target", 64'(div_target), 64'd0);
    repeat (2) @(negedge pulse_clock);
    external_reset_n = 1'b1;
    @(negedge pulse_clock);
    check("idle_cfg_ready", 64'(host_if.cfg_ready), 64'd1);

    // Rejected configuration, start ignored in IDLE, then a legal one.
    cfg_apply(1, 3);
    check("reject_cfg_error", 64'(host_if.cfg_error), 64'd1);
    check("reject_cfg_ready", 64'(host_if.cfg_ready), 64'd1);
    host_if.start = 1'b1;
    repeat (3) @(negedge pulse_clock);
    host_if.start = 1'b0;
    check("idle_start_ignored", 64'(host_if.busy), 64'd0);
    check("cfg_error_sticky", 64'(host_if.cfg_error), 64'd1);
    cfg_apply(6, 0);
    check("accept_clears_error", 64'(host_if.cfg_error), 64'd0);
    check("accept_div_target", 64'(div_target), 64'd5);

    // Four-edge burst with 10-pulse half-periods.
    cfg_apply(10, 4);
    check("burst_div_target", 64'(div_target), 64'd9);
    run_burst(10, 4);
    check("post_burst_busy", 64'(host_if.busy), 64'd0);

    // Continuous mode, abort coincident with div_toggle (even and odd flip counts).
    for (int j = 0; j < 2; j++) begin
      n = (j == 0) ? 20 : 7;
      t = $urandom_range(2, 5);
      cfg_apply(t, 0);
      pulse_start(k);
      push_cont(t, n, k);
      if ((n % 2) == 1) sb.push_back({32'(k + t * (n + 1)), 1'b0, 1'b0});
      release_start();
      while (cyc < k + t * (n + 1) - 1) @(negedge pulse_clock);
      host_if.abort = 1'b1;
      check("toggle_with_abort", 64'(div_toggle), 64'd1);
      @(negedge pulse_clock);
      host_if.abort = 1'b0;
      check("abort_divided_clock", 64'(divided_clock), 64'd0);
      check("abort_to_armed", 64'({host_if.busy, host_if.cfg_ready, div_enable, div_reset}), 64'b0101);
      repeat (4) @(negedge pulse_clock);
      check("abort_sb_drained", 64'(sb.size()), 64'd0);
    end

    // Odd burst, then immediate restart without reconfiguration.
    t = $urandom_range(2, 12);
    cfg_apply(t, 3);
    run_burst(t, 3);
    run_burst(t, 3);

    // Config and start together in ARMED: config wins, no burst.
    @(negedge pulse_clock);
    host_if.cfg_valid  = 1'b1;
    host_if.cfg_target = 32'd8;
    host_if.cfg_count  = 16'd2;
    host_if.start      = 1'b1;
    @(negedge pulse_clock);
    host_if.cfg_valid  = 1'b0;
    host_if.start      = 1'b0;
    check("cfg_start_div_target", 64'(div_target), 64'd7);
    check("cfg_start_no_burst", 64'(host_if.busy), 64'd0);
    @(negedge pulse_clock);
    check("cfg_start_still_armed", 64'({host_if.busy, host_if.cfg_ready}), 64'b01);
    run_burst(8, 2);

    // Randomised bursts including the minimum legal target.
    for (int j = 0; j < 6; j++) begin
      t = (j == 0) ? 2 : $urandom_range(2, 9);
      c = $urandom_range(1, 5);
      cfg_apply(t, c);
      check("rand_div_target", 64'(div_target), 64'(t - 1));
      run_burst(t, c);
    end

    // Asynchronous reset between clock edges mid-RUN.
    cfg_apply(20, 0);
    pulse_start(k);
    push_cont(20, 1, k);
    release_start();
    while (cyc < k + 30) @(negedge pulse_clock);
    check("pre_reset_sb_drained", 64'(sb.size()), 64'd0);
    check("pre_reset_high", 64'(divided_clock), 64'd1);
    @(posedge pulse_clock);
    #2 external_reset_n = 1'b0;
    #1;
    check("areset_div_reset", 64'(div_reset), 64'd1);
    check("areset_outputs", 64'({divided_clock, host_if.busy, div_enable}), 64'd0);
    repeat (2) @(negedge pulse_clock);
    external_reset_n = 1'b1;
    @(negedge pulse_clock);
    check("release_cfg_ready", 64'(host_if.cfg_ready), 64'd1);
    host_if.start = 1'b1;
    repeat (3) @(negedge pulse_clock);
    host_if.start = 1'b0;
    check("release_start_ignored", 64'(host_if.busy), 64'd0);
    cfg_apply(5, 2);
    check("release_div_target", 64'(div_target), 64'd4);
    run_burst(5, 2);

    repeat (3) @(negedge pulse_clock);
    check("final_sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
